// File: rtl/mem_arb_pkg.sv
// Purpose: shared types for the backing-memory arbiter (FSM states, grant encoding, beat-width helper).
// Latency: none, types and constant functions only.
// Backpressure: not applicable.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RDATA,
      S_WDATA,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      G_NONE,
      G_IC,
      G_DC
   } grant_t;

   // Width of the beat counter for a burst of burst_len beats.
   function automatic int beat_w(input int burst_len);
      return $clog2(burst_len);
   endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Purpose: picks which cache wins the memory port; ARB_ROUND_ROBIN_EN alternates on ties, else D$ wins ties.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is acted on.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic   ic_valid,
   input  logic   dc_valid,
`ifdef ARB_ROUND_ROBIN_EN
   input  grant_t last_grant,
`endif
   output grant_t grant
);

   // Resolve the winner; a single requester always wins, ties depend on the build.
   always_comb begin
      grant = G_NONE;
      if (ic_valid && dc_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant = (last_grant == G_DC) ? G_IC : G_DC;
`else
         grant = G_DC;
`endif
      end else if (dc_valid) begin
         grant = G_DC;
      end else if (ic_valid) begin
         grant = G_IC;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one burst memory port between I$ fill and D$ fill/writeback; ARB_ROUND_ROBIN_EN picks tie policy.
// Latency: request accepted in IDLE, memory request next cycle, BURST_LEN beats, one DONE cycle, back to IDLE.
// Backpressure: loser's ready stays low until the granted burst completes; beats wait on mem_*_ready/valid.
module cache_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int  ADDR_W    = 32,
   parameter int  DATA_W    = 32,
   parameter int  BURST_LEN = 4,
   localparam int BEAT_W    = beat_w(BURST_LEN)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   input  logic              dc_req_valid,
   input  logic              dc_req_wr,
   input  logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_ready,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              ic_rdata_valid,
   output logic              dc_rdata_valid,
   output logic [BEAT_W-1:0] beat_idx,
   output logic              ic_done,
   output logic              dc_done,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_wr,
   output logic              mem_wdata_valid,
   input  logic              mem_wdata_ready,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rdata_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   // Byte offset bits within one line; cleared on the outgoing burst address.
   localparam int OFF_W = $clog2(BURST_LEN * DATA_W / 8);

   state_t            state;
   grant_t            grant;
   grant_t            pick;
   logic [ADDR_W-1:0] sel_addr;
   logic              last_beat;
   logic              unused_bits;
`ifdef ARB_ROUND_ROBIN_EN
   grant_t            last_grant;
`endif

   mem_arb_grant u_grant (
      .ic_valid   (ic_req_valid),
      .dc_valid   (dc_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (last_grant),
`endif
      .grant      (pick)
   );

   assign sel_addr  = (pick == G_IC) ? ic_req_addr : dc_req_addr;
   assign last_beat = (beat_idx == BEAT_W'(BURST_LEN - 1));

   // Caches read mem_rdata directly; only the valid strobes are steered here.
   assign unused_bits = ^{mem_rdata, sel_addr[OFF_W-1:0]};

   // Acceptance is only offered in IDLE and never while reset is asserted.
   assign ic_req_ready   = rst && (state == S_IDLE) && (pick == G_IC);
   assign dc_req_ready   = rst && (state == S_IDLE) && (pick == G_DC);
   assign ic_rdata_valid = (state == S_RDATA) && mem_rdata_valid && (grant == G_IC);
   assign dc_rdata_valid = (state == S_RDATA) && mem_rdata_valid && (grant == G_DC);
   assign mem_wdata      = dc_wdata;
   assign stall          = (state != S_IDLE) || ic_req_valid || dc_req_valid;

   // Burst sequencer: arbitrate in IDLE, hold the request, count beats, pulse done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_IDLE;
         grant           <= G_NONE;
         beat_idx        <= '0;
         mem_req_valid   <= 1'b0;
         mem_req_addr    <= '0;
         mem_req_wr      <= 1'b0;
         mem_wdata_valid <= 1'b0;
         ic_done         <= 1'b0;
         dc_done         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant      <= G_IC;
`endif
      end else begin
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick != G_NONE) begin
                  grant         <= pick;
                  mem_req_addr  <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  mem_req_wr    <= (pick == G_DC) && dc_req_wr;
                  mem_req_valid <= 1'b1;
                  state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat_idx      <= '0;
                  if (mem_req_wr) begin
                     mem_wdata_valid <= 1'b1;
                     state           <= S_WDATA;
                  end else begin
                     state <= S_RDATA;
                  end
               end
            end
            S_RDATA: begin
               if (mem_rdata_valid) begin
                  if (last_beat) begin
                     beat_idx <= '0;
                     ic_done  <= (grant == G_IC);
                     dc_done  <= (grant == G_DC);
                     state    <= S_DONE;
                  end else begin
                     beat_idx <= beat_idx + BEAT_W'(1);
                  end
               end
            end
            S_WDATA: begin
               if (mem_wdata_ready) begin
                  if (last_beat) begin
                     beat_idx        <= '0;
                     mem_wdata_valid <= 1'b0;
                     ic_done         <= (grant == G_IC);
                     dc_done         <= (grant == G_DC);
                     state           <= S_DONE;
                  end else begin
                     beat_idx <= beat_idx + BEAT_W'(1);
                  end
               end
            end
            S_DONE: begin
`ifdef ARB_ROUND_ROBIN_EN
               last_grant <= grant;
`endif
               grant <= G_NONE;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
